// File: rtl/fetch_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
//   Instruction buffer sitting between the icache and decode. It takes one
//   fetch group of up to four instructions per cycle and presents the two
//   oldest buffered instructions, each with its PC, to decode. A redirect
//   (flush) empties the queue in one cycle.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst        in   synchronous reset, active-high, highest priority
//   flush      in   discard every entry this cycle (branch/exception redirect)
//   in_valid   in   fetch group present on in_pc/in_inst/in_num
//   in_pc      in   PC of in_inst[0], word-aligned
//   in_inst    in   fetch group, in_inst[i] lives at in_pc + 4*i
//   in_num     in   number of valid instructions in the group (1..4)
//   in_ready   out  room for a full four-wide group (registered count only)
//   out_valid  out  slot occupancy, out_valid[1] implies out_valid[0]
//   out_inst   out  oldest instructions, slot 0 is the oldest
//   out_pc     out  PC of each out_inst slot
//   deq_num    in   instructions consumed by decode this cycle (0..2)
//   count      out  current occupancy
// ----------------------------------------------------------------------------
module fetch_queue #(
  parameter  int DEPTH = 16,
  localparam int ENQ_W = 4,
  localparam int DEQ_W = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [31:0]            in_pc,
  input  logic [ENQ_W-1:0][31:0] in_inst,
  input  logic [2:0]             in_num,
  output logic                   in_ready,
  output logic [DEQ_W-1:0]       out_valid,
  output logic [DEQ_W-1:0][31:0] out_inst,
  output logic [DEQ_W-1:0][31:0] out_pc,
  input  logic [1:0]             deq_num,
  output logic [CNT_W-1:0]       count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             enq_fire;
  logic [CNT_W-1:0] enq_n;
  logic [PTR_W-1:0] rd_idx1;

  // The ready check uses only the registered count: a dequeue in the same
  // cycle does not make room for this cycle's group.
  assign in_ready = (count_q <= CNT_W'(DEPTH - ENQ_W));
  assign enq_fire = in_valid && in_ready && !flush;
  assign enq_n    = enq_fire ? CNT_W'(in_num) : '0;
  assign count    = count_q;

  // Pointer and occupancy next-state. Flush wins over the same-cycle
  // enqueue and dequeue.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(deq_num);
      tail_d  = tail_q + PTR_W'(enq_n);
      count_d = count_q + enq_n - CNT_W'(deq_num);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments so all
    // registers sample the pre-edge values of each other.
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry i of the group lands at tail+i (mod DEPTH); the pointer arithmetic
  // wraps naturally at PTR_W bits, and the PC add wraps at 32 bits.
  always_ff @(posedge clk) begin
    // NOTE: the data array has no reset; occupancy alone decides whether an
    // entry is visible, so stale contents are never observed.
    if (enq_fire && !rst) begin
      for (int i = 0; i < ENQ_W; i++) begin
        if (3'(i) < in_num) begin
          mem_q[tail_q + PTR_W'(i)] <= '{pc: in_pc + 32'(4 * i), inst: in_inst[i]};
        end
      end
    end
  end

  // Read ports: head and head+1, zeroed when the slot is empty.
  assign rd_idx1 = head_q + PTR_W'(1);

  always_comb begin
    out_valid = '0;
    out_inst  = '0;
    out_pc    = '0;
    if (count_q != '0) begin
      out_valid[0] = 1'b1;
      out_inst[0]  = mem_q[head_q].inst;
      out_pc[0]    = mem_q[head_q].pc;
    end
    if (count_q >= CNT_W'(2)) begin
      out_valid[1] = 1'b1;
      out_inst[1]  = mem_q[rd_idx1].inst;
      out_pc[1]    = mem_q[rd_idx1].pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// ----------------------------------------------------------------------------
// tb_fetch_queue
//   Directed bench for fetch_queue (DEPTH=16). A table of one-cycle vectors
//   drives the inputs; after each rising edge the registered state seen on
//   the outputs is compared with hand-computed values. Reset priority and
//   the flush corner are written out as explicit sequences.
//   Instruction words are derived from their PC so each slot's inst can be
//   tied back to the PC it should carry.
// ----------------------------------------------------------------------------
module tb_fetch_queue;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic [31:0]      in_pc;
  logic [3:0][31:0] in_inst;
  logic [2:0]       in_num;
  logic             in_ready;
  logic [1:0]       out_valid;
  logic [1:0][31:0] out_inst;
  logic [1:0][31:0] out_pc;
  logic [1:0]       deq_num;
  logic [4:0]       count;

  int tests  = 0;
  int failed = 0;

  fetch_queue #(.DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_pc     (in_pc),
    .in_inst   (in_inst),
    .in_num    (in_num),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .deq_num   (deq_num),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        in_valid;
    logic [31:0] pc;
    logic [2:0]  num;
    logic [1:0]  deq;
    logic [1:0]  e_valid;
    logic [31:0] e_pc0;
    logic [31:0] e_pc1;
    logic [4:0]  e_count;
    logic        e_ready;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [31:0] iw(input logic [31:0] pc);
    return {16'hBEEF, pc[15:0]};
  endfunction

  function automatic vec_t mk(input logic f, input logic v, input logic [31:0] pc,
                              input logic [2:0] n, input logic [1:0] d,
                              input logic [1:0] ev, input logic [31:0] p0,
                              input logic [31:0] p1, input logic [4:0] c,
                              input logic r);
    vec_t t;
    t.flush = f; t.in_valid = v; t.pc = pc; t.num = n; t.deq = d;
    t.e_valid = ev; t.e_pc0 = p0; t.e_pc1 = p1; t.e_count = c; t.e_ready = r;
    return t;
  endfunction

  task automatic drive(input logic f, input logic v, input logic [31:0] pc,
                       input logic [2:0] n, input logic [1:0] d);
    flush    = f;
    in_valid = v;
    in_pc    = pc;
    in_num   = n;
    deq_num  = d;
    for (int i = 0; i < 4; i++) in_inst[i] = iw(pc + 32'(4 * i));
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Compares every output against the expected state; inst and pc of an
  // empty slot must read as zero.
  task automatic expect_state(input string tag, input logic [1:0] v,
                              input logic [31:0] p0, input logic [31:0] p1,
                              input logic [4:0] c, input logic r);
    check({tag, ".valid"}, 32'(out_valid), 32'(v));
    check({tag, ".inst0"}, out_inst[0], v[0] ? iw(p0) : 32'h0);
    check({tag, ".inst1"}, out_inst[1], v[1] ? iw(p1) : 32'h0);
    check({tag, ".pc0"},   out_pc[0],   v[0] ? p0 : 32'h0);
    check({tag, ".pc1"},   out_pc[1],   v[1] ? p1 : 32'h0);
    check({tag, ".count"}, 32'(count),  32'(c));
    check({tag, ".ready"}, 32'(in_ready), 32'(r));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string prefix);
    for (int k = 0; k < tbl.size(); k++) begin
      drive(tbl[k].flush, tbl[k].in_valid, tbl[k].pc, tbl[k].num, tbl[k].deq);
      tick();
      expect_state($sformatf("%s%0d", prefix, k), tbl[k].e_valid, tbl[k].e_pc0,
                   tbl[k].e_pc1, tbl[k].e_count, tbl[k].e_ready);
    end
    tbl.delete();
  endtask

  // Decode may never consume more instructions than are presented.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      assert (32'(deq_num) <= 32'(out_valid[0]) + 32'(out_valid[1]))
      else begin
        failed++;
        $display("FAIL deq_legal: deq_num=%0d with out_valid=%b", deq_num, out_valid);
      end
    end
  end

  initial begin
    // Reset has priority over a simultaneous enqueue.
    rst = 1'b1;
    drive(1'b0, 1'b1, 32'h1000, 3'd4, 2'd0);
    tick();
    tick();
    expect_state("rst", 2'b00, 0, 0, 5'd0, 1'b1);
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 3'd0, 2'd0);
    tick();
    expect_state("idle", 2'b00, 0, 0, 5'd0, 1'b1);

    // Basic enqueue/dequeue, simultaneous enq+deq, fill to full, held group.
    tbl.push_back(mk(0, 1, 32'h1000, 4, 0, 2'b11, 32'h1000, 32'h1004, 4,  1));
    tbl.push_back(mk(0, 0, 32'h0,    0, 2, 2'b11, 32'h1008, 32'h100C, 2,  1));
    tbl.push_back(mk(0, 0, 32'h0,    0, 2, 2'b00, 0,        0,        0,  1));
    tbl.push_back(mk(0, 1, 32'h2000, 3, 0, 2'b11, 32'h2000, 32'h2004, 3,  1));
    tbl.push_back(mk(0, 1, 32'h3000, 4, 1, 2'b11, 32'h2004, 32'h2008, 6,  1));
    tbl.push_back(mk(0, 1, 32'h4000, 2, 2, 2'b11, 32'h3000, 32'h3004, 6,  1));
    tbl.push_back(mk(0, 0, 32'h0,    0, 1, 2'b11, 32'h3004, 32'h3008, 5,  1));
    tbl.push_back(mk(0, 1, 32'h5000, 4, 0, 2'b11, 32'h3004, 32'h3008, 9,  1));
    tbl.push_back(mk(0, 1, 32'h6000, 3, 0, 2'b11, 32'h3004, 32'h3008, 12, 1));
    tbl.push_back(mk(0, 1, 32'h7000, 4, 0, 2'b11, 32'h3004, 32'h3008, 16, 0));
    tbl.push_back(mk(0, 1, 32'h8000, 4, 0, 2'b11, 32'h3004, 32'h3008, 16, 0));
    tbl.push_back(mk(0, 1, 32'h8000, 4, 2, 2'b11, 32'h300C, 32'h4000, 14, 0));
    tbl.push_back(mk(0, 1, 32'h8000, 4, 2, 2'b11, 32'h4004, 32'h5000, 12, 1));
    tbl.push_back(mk(0, 1, 32'h8000, 4, 0, 2'b11, 32'h4004, 32'h5000, 16, 0));
    run_table("A");

    // Flush with a same-cycle enqueue and dequeue at count=6.
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 32'h0, 3'd0, 2'd2);
      tick();
    end
    expect_state("pre_flush", 2'b11, 32'h7008, 32'h700C, 5'd6, 1'b1);
    drive(1'b1, 1'b1, 32'hA000, 3'd4, 2'd2);
    tick();
    expect_state("flush", 2'b00, 0, 0, 5'd0, 1'b1);
    drive(1'b0, 1'b1, 32'h9000, 3'd2, 2'd0);
    tick();
    expect_state("post_flush", 2'b11, 32'h9000, 32'h9004, 5'd2, 1'b1);

    // Walk tail to 14, wrap a group across index 15->0, then a 32-bit PC wrap.
    tbl.push_back(mk(0, 0, 32'h0,        0, 2, 2'b00, 0,            0,            0, 1));
    tbl.push_back(mk(0, 1, 32'hB000,     4, 0, 2'b11, 32'hB000,     32'hB004,     4, 1));
    tbl.push_back(mk(0, 1, 32'hC000,     4, 2, 2'b11, 32'hB008,     32'hB00C,     6, 1));
    tbl.push_back(mk(0, 1, 32'hD000,     4, 2, 2'b11, 32'hC000,     32'hC004,     8, 1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 2, 2'b11, 32'hC008,     32'hC00C,     6, 1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 2, 2'b11, 32'hD000,     32'hD004,     4, 1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 1, 2'b11, 32'hD004,     32'hD008,     3, 1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 2, 2'b01, 32'hD00C,     0,            1, 1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 1, 2'b00, 0,            0,            0, 1));
    tbl.push_back(mk(0, 1, 32'h2000,     4, 0, 2'b11, 32'h2000,     32'h2004,     4, 1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 2, 2'b11, 32'h2008,     32'h200C,     2, 1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 2, 2'b00, 0,            0,            0, 1));
    tbl.push_back(mk(0, 1, 32'hFFFFFFF8, 4, 0, 2'b11, 32'hFFFFFFF8, 32'hFFFFFFFC, 4, 1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 2, 2'b11, 32'h00000000, 32'h00000004, 2, 1));
    tbl.push_back(mk(0, 0, 32'h0,        0, 2, 2'b00, 0,            0,            0, 1));
    run_table("B");

    drive(1'b0, 1'b0, 32'h0, 3'd0, 2'd0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
